zeroriscy_rf_wport_sched: RTL and testbench

//  Write-port scheduler for the core's single-write-port latch register file.
//  - Shares the port between the ALU/EX writeback and in-order LSU load writebacks.
//  - Holds each outstanding load in an in-order queue: slot reserved at issue, data filled at response.
//  - Drains filled loads into the register file when the port is free.
//  - Exports per-read-port busy flags (load hazards) to the decoder.

---
 rtl/zeroriscy_rf_wport_sched.sv | 204 ++++++++++++++++++++
 tb/tb_zeroriscy_rf_wport_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_rf_wport_sched.sv
// Write-port scheduler for the single-write-port register file: arbitrates the ALU
// writeback against an in-order load queue. Optional forwarding: ZERORISCY_RF_WPORT_FWD_EN.
module zeroriscy_rf_wport_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int LSU_DEPTH  = 2,
    parameter bit RV32E      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_we_i,
    input  logic [4:0]            alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    output logic                  alu_gnt_o,
    input  logic                  lsu_issue_i,
    input  logic [4:0]            lsu_issue_addr_i,
    output logic                  lsu_issue_rdy_o,
    input  logic                  lsu_rvalid_i,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  fwd_a_o,
    output logic                  fwd_b_o,
    output logic [DATA_WIDTH-1:0] fwd_data_a_o,
    output logic [DATA_WIDTH-1:0] fwd_data_b_o,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  proto_err_o
);

    localparam int PW = $clog2(LSU_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(LSU_DEPTH);

    logic [4:0]            r_addr [LSU_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [LSU_DEPTH];
    logic [LSU_DEPTH-1:0]  r_valid;
    logic [LSU_DEPTH-1:0]  r_filled;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [PW-1:0]         r_fill;
    logic [PW:0]           r_count;
    logic                  r_proto_err;

    logic [LSU_DEPTH-1:0]  w_match_alu;
    logic [LSU_DEPTH-1:0]  w_match_a;
    logic [LSU_DEPTH-1:0]  w_match_b;
    logic                  w_full;
    logic                  w_head_filled;
    logic                  w_alu_hz;
    logic                  w_alu_gnt;
    logic                  w_drain;
    logic                  w_push;
    logic                  w_has_unfilled;
    logic                  w_fill;

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
        if (RV32E) return a[3:0] == b[3:0];
        else       return a == b;
    endfunction

    function automatic logic addr_nz(input logic [4:0] a);
        if (RV32E) return a[3:0] != 4'd0;
        else       return a != 5'd0;
    endfunction

    generate
        for (genvar gi = 0; gi < LSU_DEPTH; gi++) begin : g_match
            assign w_match_alu[gi] = r_valid[gi] && addr_eq(r_addr[gi], alu_waddr_i);
            assign w_match_a[gi]   = r_valid[gi] && addr_eq(r_addr[gi], raddr_a_i);
            assign w_match_b[gi]   = r_valid[gi] && addr_eq(r_addr[gi], raddr_b_i);
        end
    endgenerate

    // A full queue with a ready head must drain first, otherwise no new load could ever issue.
    assign w_full         = (r_count == FULL_CNT);
    assign w_head_filled  = r_valid[r_head] && r_filled[r_head];
    assign w_alu_hz       = alu_we_i && addr_nz(alu_waddr_i) && (|w_match_alu);
    assign w_alu_gnt      = !rst && alu_we_i && !w_alu_hz && !(w_full && w_head_filled);
    assign w_drain        = !rst && w_head_filled && !w_alu_gnt;
    assign w_push         = !rst && lsu_issue_i && !w_full;
    assign w_has_unfilled = r_valid[r_fill] && !r_filled[r_fill];
    assign w_fill         = !rst && lsu_rvalid_i && w_has_unfilled;

    assign alu_gnt_o       = w_alu_gnt;
    assign lsu_issue_rdy_o = rst || !w_full;
    assign proto_err_o     = r_proto_err;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = '0;
        if (w_alu_gnt) begin
            rf_we_o    = addr_nz(alu_waddr_i);
            rf_waddr_o = alu_waddr_i;
            rf_wdata_o = alu_wdata_i;
        end else if (w_drain) begin
            rf_we_o    = addr_nz(r_addr[r_head]);
            rf_waddr_o = r_addr[r_head];
            rf_wdata_o = r_data[r_head];
        end
    end

`ifdef ZERORISCY_RF_WPORT_FWD_EN
    typedef struct packed {
        logic                  busy;
        logic                  fwd;
        logic [DATA_WIDTH-1:0] data;
    } rd_res_t;

    // Walk the queue oldest-to-youngest; the last match is the value the register will end up with.
    function automatic rd_res_t lookup(input logic [LSU_DEPTH-1:0] match, input logic [4:0] raddr);
        rd_res_t               res;
        logic                  found;
        logic                  last_filled;
        logic                  older_unfilled;
        logic [DATA_WIDTH-1:0] last_data;
        logic [PW-1:0]         idx;
        res            = '0;
        found          = 1'b0;
        last_filled    = 1'b0;
        older_unfilled = 1'b0;
        last_data      = '0;
        idx            = '0;
        for (int k = 0; k < LSU_DEPTH; k++) begin
            idx = r_head + PW'(k);
            if (match[idx]) begin
                older_unfilled = older_unfilled | (found & !last_filled);
                found          = 1'b1;
                last_filled    = r_filled[idx];
                last_data      = r_data[idx];
            end
        end
        res.fwd  = found && last_filled;
        res.data = res.fwd ? last_data : '0;
        res.busy = found && (!last_filled || older_unfilled);
        if (!addr_nz(raddr)) res = '0;
        return res;
    endfunction

    rd_res_t w_res_a;
    rd_res_t w_res_b;

    always_comb begin
        w_res_a = '0;
        w_res_b = '0;
        if (!rst) begin
            w_res_a = lookup(w_match_a, raddr_a_i);
            w_res_b = lookup(w_match_b, raddr_b_i);
        end
    end

    assign busy_a_o     = w_res_a.busy;
    assign busy_b_o     = w_res_b.busy;
    assign fwd_a_o      = w_res_a.fwd;
    assign fwd_b_o      = w_res_b.fwd;
    assign fwd_data_a_o = w_res_a.data;
    assign fwd_data_b_o = w_res_b.data;
`else
    assign busy_a_o     = !rst && addr_nz(raddr_a_i) && (|w_match_a);
    assign busy_b_o     = !rst && addr_nz(raddr_b_i) && (|w_match_b);
    assign fwd_a_o      = 1'b0;
    assign fwd_b_o      = 1'b0;
    assign fwd_data_a_o = '0;
    assign fwd_data_b_o = '0;
`endif

    // Drain, push and fill never target the same entry, so their updates can stack freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_filled    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= lsu_rvalid_i && !w_has_unfilled;
            if (w_drain) begin
                r_valid[r_head]  <= 1'b0;
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail]  <= 1'b1;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + 1'b1;
            end
            if (w_fill) begin
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_drain};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_addr[r_tail] <= lsu_issue_addr_i;
        if (w_fill) r_data[r_fill] <= lsu_rdata_i;
    end

endmodule

// File: tb/tb_zeroriscy_rf_wport_sched.sv
// Directed bench for zeroriscy_rf_wport_sched (LSU_DEPTH=2); adapts scenario 6 to ZERORISCY_RF_WPORT_FWD_EN.
module tb_zeroriscy_rf_wport_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we_i;
    logic [4:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        alu_gnt_o;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_addr_i;
    logic        lsu_issue_rdy_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic        busy_a_o;
    logic        busy_b_o;
    logic        fwd_a_o;
    logic        fwd_b_o;
    logic [31:0] fwd_data_a_o;
    logic [31:0] fwd_data_b_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        proto_err_o;

    int n_checks = 0;
    int n_errors = 0;

    zeroriscy_rf_wport_sched #(.DATA_WIDTH(32), .LSU_DEPTH(2), .RV32E(1'b0)) dut (
        .clk(clk), .rst(rst),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i), .alu_gnt_o(alu_gnt_o),
        .lsu_issue_i(lsu_issue_i), .lsu_issue_addr_i(lsu_issue_addr_i), .lsu_issue_rdy_o(lsu_issue_rdy_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .busy_a_o(busy_a_o), .busy_b_o(busy_b_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_we_i     = 1'b0;
        alu_waddr_i  = 5'd0;
        alu_wdata_i  = 32'd0;
        lsu_issue_i  = 1'b0;
        lsu_rvalid_i = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        lsu_issue_i      = 1'b1;
        lsu_issue_addr_i = a;
    endtask

    task automatic respond(input logic [31:0] d);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = d;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        alu_we_i    = 1'b1;
        alu_waddr_i = a;
        alu_wdata_i = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        lsu_issue_addr_i = 5'd0;
        lsu_rdata_i      = 32'd0;
        raddr_a_i        = 5'd5;
        raddr_b_i        = 5'd0;
        alu(5'd7, 32'h77);
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_gnt", alu_gnt_o, 0);
        check("rst_rf_we", rf_we_o, 0);
        check("rst_rdy", lsu_issue_rdy_o, 1);
        check("rst_busy_a", busy_a_o, 0);
        check("rst_proto_err", proto_err_o, 0);
        rst = 1'b0;
        idle();
        $display("reset done");

        // 1: load x5 round trip
        issue(5'd5); #1;
        check("s1_busy_before", busy_a_o, 0);
        tick(); idle(); respond(32'hDEADBEEF); #1;
        check("s1_busy_pending", busy_a_o, 1);
        check("s1_no_write_yet", rf_we_o, 0);
        tick(); idle(); #1;
        check("s1_drain_we", rf_we_o, 1);
        check("s1_drain_waddr", rf_waddr_o, 5);
        check("s1_drain_wdata", rf_wdata_o, 32'hDEADBEEF);
        tick(); #1;
        check("s1_busy_after", busy_a_o, 0);
        check("s1_idle_we", rf_we_o, 0);
        $display("scenario 1 load x5 done");

        // 2: queue full, third issue ignored
        issue(5'd3); tick();
        issue(5'd4); tick();
        issue(5'd6); #1;
        check("s2_rdy_full", lsu_issue_rdy_o, 0);
        tick(); idle(); raddr_a_i = 5'd3; raddr_b_i = 5'd6; #1;
        check("s2_third_ignored", busy_b_o, 0);
        check("s2_busy_x3", busy_a_o, 1);
        respond(32'h33); tick(); idle(); #1;
        check("s2_drain_waddr", rf_waddr_o, 3);
        check("s2_drain_wdata", rf_wdata_o, 32'h33);
        check("s2_rdy_still_full", lsu_issue_rdy_o, 0);
        tick(); #1;
        check("s2_rdy_after_drain", lsu_issue_rdy_o, 1);
        respond(32'h44); tick(); idle(); #1;
        check("s2_drain2_waddr", rf_waddr_o, 4);
        tick();
        $display("scenario 2 full queue done");

        // 3: ALU wins over a filled head unless the queue is full
        issue(5'd8); tick(); idle();
        respond(32'h88); tick(); idle();
        alu(5'd7, 32'h77); issue(5'd10); #1;
        check("s3_alu_gnt", alu_gnt_o, 1);
        check("s3_alu_waddr", rf_waddr_o, 7);
        check("s3_alu_wdata", rf_wdata_o, 32'h77);
        tick(); lsu_issue_i = 1'b0; #1;
        check("s3_full_alu_gnt", alu_gnt_o, 0);
        check("s3_full_drain_waddr", rf_waddr_o, 8);
        check("s3_full_drain_wdata", rf_wdata_o, 32'h88);
        tick(); #1;
        check("s3_alu_after", alu_gnt_o, 1);
        check("s3_alu_after_waddr", rf_waddr_o, 7);
        tick(); idle(); respond(32'hAA); tick(); idle(); #1;
        check("s3_drain_x10", rf_waddr_o, 10);
        tick();
        $display("scenario 3 arbitration done");

        // 4: WAW hazard against pending load x9
        issue(5'd9); tick(); idle();
        alu(5'd9, 32'h99); #1;
        check("s4_hz_unissued", alu_gnt_o, 0);
        check("s4_no_write", rf_we_o, 0);
        tick(); respond(32'h19); #1;
        check("s4_hz_fill", alu_gnt_o, 0);
        tick(); lsu_rvalid_i = 1'b0; #1;
        check("s4_hz_drain", alu_gnt_o, 0);
        check("s4_drain_wdata", rf_wdata_o, 32'h19);
        tick(); #1;
        check("s4_alu_gnt", alu_gnt_o, 1);
        check("s4_alu_wdata", rf_wdata_o, 32'h99);
        tick(); idle();
        $display("scenario 4 WAW hazard done");

        // 5: x0 writes and protocol error
        raddr_a_i = 5'd0;
        issue(5'd0); #1;
        check("s5_busy_x0_issue", busy_a_o, 0);
        tick(); idle(); respond(32'h55); #1;
        check("s5_busy_x0_pend", busy_a_o, 0);
        check("s5_perr_ok", proto_err_o, 0);
        tick(); idle(); #1;
        check("s5_x0_drain_we", rf_we_o, 0);
        check("s5_x0_rdy", lsu_issue_rdy_o, 1);
        tick(); #1;
        check("s5_x0_popped_perr", proto_err_o, 0);
        alu(5'd0, 32'h5); #1;
        check("s5_alu_x0_gnt", alu_gnt_o, 1);
        check("s5_alu_x0_we", rf_we_o, 0);
        tick(); idle(); respond(32'h1); #1;
        check("s5_perr_same_cycle", proto_err_o, 0);
        tick(); idle(); #1;
        check("s5_perr_pulse", proto_err_o, 1);
        tick(); #1;
        check("s5_perr_cleared", proto_err_o, 0);
        $display("scenario 5 x0 and proto_err done");

        // 6: filled but undrained x12
        raddr_a_i = 5'd12;
        issue(5'd12); tick(); idle();
        respond(32'h1234); alu(5'd7, 32'h7); tick(); lsu_rvalid_i = 1'b0; #1;
        check("s6_alu_holds", alu_gnt_o, 1);
`ifdef ZERORISCY_RF_WPORT_FWD_EN
        check("s6_fwd_a", fwd_a_o, 1);
        check("s6_fwd_data_a", fwd_data_a_o, 32'h1234);
        check("s6_busy_a", busy_a_o, 0);
`else
        check("s6_fwd_a", fwd_a_o, 0);
        check("s6_fwd_data_a", fwd_data_a_o, 0);
        check("s6_busy_a", busy_a_o, 1);
`endif
        tick(); idle(); #1;
        check("s6_drain_wdata", rf_wdata_o, 32'h1234);
        tick();
        $display("scenario 6 forwarding done");

        // 7: issue + response together fills only the older entry
        raddr_b_i = 5'd14;
        issue(5'd13); tick();
        issue(5'd14); respond(32'hD); tick(); idle(); #1;
        check("s7_drain_x13", rf_waddr_o, 13);
        check("s7_busy_x14", busy_b_o, 1);
        tick(); #1;
        check("s7_x14_unfilled", rf_we_o, 0);
        respond(32'hE); tick(); idle(); #1;
        check("s7_drain_x14", rf_wdata_o, 32'hE);
        tick();
        $display("scenario 7 issue+response done");

        // 8: reset discards a filled pending load
        raddr_a_i = 5'd15;
        issue(5'd15); tick(); idle();
        respond(32'hF); tick(); idle();
        rst = 1'b1; #1;
        check("s8_rst_no_write", rf_we_o, 0);
        check("s8_rst_rdy", lsu_issue_rdy_o, 1);
        tick(); rst = 1'b0; #1;
        check("s8_after_rst_we", rf_we_o, 0);
        check("s8_after_rst_busy", busy_a_o, 0);
        $display("scenario 8 mid-run reset done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
